// File: rtl/aes_serial_master.sv
// aes_serial_master: host-side bit-serial front end for the Cipher/InvCipher cores.
// Takes one parallel block/key/direction request and shifts data then key out
// LSB first on mosi under the selected core's chip select. It then idles for
// the core's fixed latency, shifts the 128-bit result in from miso, and
// presents the result as a parallel word.
`timescale 1ns/1ps
module aes_serial_master #(
  parameter int KEY_BITS   = 192,
  parameter int RESP_DELAY = 175
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic                in_decrypt,
  output logic                cs_enc_n,
  output logic                cs_dec_n,
  output logic                mosi,
  input  logic                miso,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);

  localparam int BLOCK_BITS = 128;
  localparam int MAX_KD     = (KEY_BITS > RESP_DELAY) ? KEY_BITS : RESP_DELAY;
  localparam int CNT_MAX    = (MAX_KD > BLOCK_BITS) ? MAX_KD : BLOCK_BITS;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(BLOCK_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_KEY   = CNT_W'(KEY_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(RESP_DELAY - 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_serial_master: KEY_BITS must be 128, 192 or 256");
    end
    if (RESP_DELAY < 1) begin : g_bad_resp_delay
      $error("aes_serial_master: RESP_DELAY must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_DATA = 3'd1,
    SEND_KEY  = 3'd2,
    WAIT      = 3'd3,
    RECV      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    cnt;
  logic                dec;
  logic                link_active;
  logic                accept;
  logic                recv_last;
  logic [127:0]        data_sr;
  logic [KEY_BITS-1:0] key_sr;
  logic [127:0]        rx_sr;
  logic [127:0]        rx_next;

  // A request is taken only while idle and advertising ready.
  assign accept    = (state == IDLE) && in_valid && in_ready;
  assign recv_last = (state == RECV) && (cnt == LAST_BLOCK);
  // Result bits arrive LSB first, so each new sample enters at the top.
  assign rx_next   = {miso, rx_sr[127:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each link phase lasts a fixed number of cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept)              state_next = SEND_DATA;
      SEND_DATA: if (cnt == LAST_BLOCK)   state_next = SEND_KEY;
      SEND_KEY:  if (cnt == LAST_KEY)     state_next = WAIT;
      WAIT:      if (cnt == LAST_WAIT)    state_next = RECV;
      RECV:      if (cnt == LAST_BLOCK)   state_next = DONE;
      DONE:      if (out_ready)           state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Output logic: chip select spans the whole link phase, mosi idles low
  always_comb begin
    link_active = 1'b0;
    mosi        = 1'b0;
    case (state)
      SEND_DATA: begin
        link_active = 1'b1;
        mosi        = data_sr[0];
      end
      SEND_KEY: begin
        link_active = 1'b1;
        mosi        = key_sr[0];
      end
      WAIT, RECV: link_active = 1'b1;
      default: ;
    endcase
  end

  // Only one core is ever selected; the latched direction picks which.
  assign cs_enc_n = ~(link_active & ~dec);
  assign cs_dec_n = ~(link_active &  dec);

  // Control registers: phase counter, handshakes, direction, result word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      dec       <= 1'b0;
      out_data  <= '0;
    end else begin
      // Registered ready keeps it low during reset and for one cycle after.
      in_ready <= (state_next == IDLE);
      if (state_next != state) begin
        cnt <= '0;
      end else if (link_active) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (accept) begin
        dec <= in_decrypt;
      end
      if (recv_last) begin
        out_data  <= rx_next;
        out_valid <= 1'b1;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Shift registers: load on accept, then shift one bit per link cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      data_sr <= in_data;
      key_sr  <= in_key;
    end else begin
      if (state == SEND_DATA) begin
        data_sr <= data_sr >> 1;
      end
      if (state == SEND_KEY) begin
        key_sr <= key_sr >> 1;
      end
    end
    if (state == RECV) begin
      rx_sr <= rx_next;
    end
  end

  // Both chip selects low at once would put two cores on miso.
  assert property (@(posedge clk) disable iff (rst) (cs_enc_n || cs_dec_n));

  // The held result must not move until the consumer takes it.
  assert property (@(posedge clk) disable iff (rst)
                   (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

endmodule
